// File: rtl/se15_serout_if.sv
// Upstream word push, config register write and downstream byte handshake for se15_serout.
interface se15_serout_if;
  logic        pushin;
  logic [31:0] datain;
  logic        write;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        bout_valid;
  logic        bout_ready;
  logic [7:0]  bout_data;
  logic        bout_last;
  logic [7:0]  ovf_cnt;

  modport master (
    output pushin, datain, write, addr, wdata, bout_ready,
    input  bout_valid, bout_data, bout_last, ovf_cnt
  );

  modport slave (
    input  pushin, datain, write, addr, wdata, bout_ready,
    output bout_valid, bout_data, bout_last, ovf_cnt
  );
endinterface

// File: rtl/se15_serout.sv
// Word-to-byte serializer: 4-deep word FIFO feeding a registered byte stream with
// configurable byte order and a saturating dropped-word counter.
module se15_serout (
  input  logic          clk,
  input  logic          rst,
  se15_serout_if.slave  bus
);

  localparam logic [11:0] AddrCfg    = 12'h010;
  localparam logic [11:0] AddrOvfClr = 12'h014;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        order_q, order_d;
  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;
  logic        last_q, last_d;

  logic [1:0]  cfg_q;
  logic [7:0]  ovf_q;

  logic [31:0] mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;

  logic        fifo_empty, fifo_full;
  logic        push_req, push_ok, ovf_inc, load;
  logic [31:0] head;

  logic        unused_wdata;
  assign unused_wdata = ^bus.wdata[31:2];

  // Byte idx of a word in emission order; order 0 starts at the MSB.
  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic lsb_first,
                                          input logic [1:0] idx);
    logic [1:0] pos;
    pos = lsb_first ? idx : ~idx;
    return w[{pos, 3'b000} +: 8];
  endfunction

  assign fifo_empty = (count_q == 3'd0);
  assign fifo_full  = (count_q == 3'd4);
  assign head       = mem_q[rd_ptr_q];

  // en is taken from the register before any same-edge config write.
  assign push_req = bus.pushin & cfg_q[1];
  assign push_ok  = push_req & (~fifo_full | load);
  assign ovf_inc  = push_req & fifo_full & ~load;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    order_d = order_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) load = 1'b1;
      end
      StShift: begin
        if (bus.bout_ready) begin
          if (idx_q == 2'd3) begin
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
              valid_d = 1'b0;
              last_d  = 1'b0;
              idx_d   = 2'd0;
            end
          end else begin
            idx_d  = idx_q + 2'd1;
            data_d = sel_byte(word_q, order_q, idx_q + 2'd1);
            last_d = (idx_q == 2'd2);
          end
        end
      end
      default: ;
    endcase

    if (load) begin
      state_d = StShift;
      word_d  = head;
      order_d = cfg_q[0];
      idx_d   = 2'd0;
      valid_d = 1'b1;
      data_d  = sel_byte(head, cfg_q[0], 2'd0);
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      word_q  <= 32'h0;
      order_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      order_q <= order_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= 32'h0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= bus.datain;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (load) rd_ptr_q <= rd_ptr_q + 2'd1;
      if (push_ok && !load)      count_q <= count_q + 3'd1;
      else if (!push_ok && load) count_q <= count_q - 3'd1;
    end
  end

  // Clear wins over a same-edge overflow increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q <= 2'b10;
      ovf_q <= 8'h00;
    end else begin
      if (bus.write && bus.addr == AddrCfg) cfg_q <= bus.wdata[1:0];
      if (bus.write && bus.addr == AddrOvfClr) ovf_q <= 8'h00;
      else if (ovf_inc && ovf_q != 8'hff)      ovf_q <= ovf_q + 8'd1;
    end
  end

  assign bus.bout_valid = valid_q;
  assign bus.bout_data  = data_q;
  assign bus.bout_last  = last_q;
  assign bus.ovf_cnt    = ovf_q;

endmodule
